// File: rtl/stopwatch_pkg.sv
// Shared types and default rate constants for the stopwatch control sequencer.
// Also holds small helpers used for divider sizing and resume-state toggling.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSE  = 2'd1,
        ST_ADJUST = 2'd2
    } state_e;

    localparam int DEFAULT_CLK_HZ    = 100_000_000;
    localparam int DEFAULT_TICK_HZ   = 1;
    localparam int DEFAULT_ADJ_HZ    = 2;
    localparam int DEFAULT_DB_CYCLES = 1_000_000;

    // Counter width for a terminal count, never narrower than one bit.
    function automatic int cnt_width(input int tc);
        return (tc > 1) ? $clog2(tc) : 1;
    endfunction

    function automatic state_e toggle_resume(input state_e s);
        return (s == ST_RUN) ? ST_PAUSE : ST_RUN;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// pulse on each rising edge of the accepted level.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q,  sync_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // Next-state: count consecutive samples that disagree with the accepted level.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = {CW{1'b0}};
            level_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        press_d = level_d & ~level_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: RUN/PAUSE/ADJUST FSM, tick and adjust dividers,
// and registered strobes toward the seconds/minutes counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = DEFAULT_CLK_HZ,
    parameter int TICK_HZ   = DEFAULT_TICK_HZ,
    parameter int ADJ_HZ    = DEFAULT_ADJ_HZ,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_pause,
    input  logic btn_reset,
    input  logic sw_adj,
    input  logic sw_sel,
    output logic cnt_en,
    output logic adj_tick,
    output logic adj_min,
    output logic adj_sec,
    output logic clr,
    output logic paused,
    output logic blink
);

    localparam int            TICK_TC   = CLK_HZ / TICK_HZ;
    localparam int            ADJ_TC    = CLK_HZ / ADJ_HZ;
    localparam int            TW        = cnt_width(TICK_TC);
    localparam int            AW        = cnt_width(ADJ_TC);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_TC - 1);
    localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_TC - 1);

    logic pause_press;
    logic reset_press;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_pause),
        .press   (pause_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_reset),
        .press   (reset_press)
    );

    logic [1:0]    adj_sync_q,  adj_sync_d;
    logic [1:0]    sel_sync_q,  sel_sync_d;
    state_e        state_q,     state_d;
    state_e        resume_q,    resume_d;
    logic [TW-1:0] tick_cnt_q,  tick_cnt_d;
    logic [AW-1:0] adj_cnt_q,   adj_cnt_d;
    logic          cnt_en_q,    cnt_en_d;
    logic          adj_tick_q,  adj_tick_d;
    logic          adj_min_q,   adj_min_d;
    logic          adj_sec_q,   adj_sec_d;
    logic          clr_q,       clr_d;
    logic          paused_q,    paused_d;
    logic          blink_q,     blink_d;

    logic adj_on;
    logic sel_min;
    assign adj_on  = adj_sync_q[1];
    assign sel_min = sel_sync_q[1];

    // FSM next-state, divider updates and next values of the output registers.
    always_comb begin
        adj_sync_d = {adj_sync_q[0], sw_adj};
        sel_sync_d = {sel_sync_q[0], sw_sel};
        state_d    = state_q;
        resume_d   = resume_q;
        tick_cnt_d = tick_cnt_q;
        adj_cnt_d  = adj_cnt_q;
        cnt_en_d   = 1'b0;
        adj_tick_d = 1'b0;
        blink_d    = blink_q;

        case (state_q)
            ST_RUN: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = {TW{1'b0}};
                    cnt_en_d   = 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
                if (adj_on) begin
                    state_d  = ST_ADJUST;
                    resume_d = pause_press ? ST_PAUSE : ST_RUN;
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (adj_on) begin
                    state_d  = ST_ADJUST;
                    resume_d = pause_press ? ST_RUN : ST_PAUSE;
                end else if (pause_press) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_ADJUST: begin
                resume_d = pause_press ? toggle_resume(resume_q) : resume_q;
                if (adj_on) begin
                    if (adj_cnt_q == ADJ_LAST) begin
                        adj_cnt_d  = {AW{1'b0}};
                        adj_tick_d = 1'b1;
                        blink_d    = ~blink_q;
                    end else begin
                        adj_cnt_d = adj_cnt_q + AW'(1);
                    end
                end else begin
                    state_d = resume_d;
                end
            end
            default: begin
                state_d  = ST_RUN;
                resume_d = ST_RUN;
            end
        endcase

        // A reset press wins over a wrap in the same cycle.
        if (reset_press) begin
            tick_cnt_d = {TW{1'b0}};
            cnt_en_d   = 1'b0;
        end else begin
            tick_cnt_d = tick_cnt_d;
        end

        if (state_d != ST_ADJUST) begin
            blink_d = 1'b0;
        end else if (state_q != ST_ADJUST) begin
            adj_cnt_d = {AW{1'b0}};
            blink_d   = 1'b0;
        end else begin
            blink_d = blink_d;
        end

        clr_d     = reset_press;
        paused_d  = (state_d == ST_PAUSE) ||
                    ((state_d == ST_ADJUST) && (resume_d == ST_PAUSE));
        adj_min_d = (state_d == ST_ADJUST) &&  sel_min;
        adj_sec_d = (state_d == ST_ADJUST) && !sel_min;
    end

    // State, divider and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_sync_q <= 2'b00;
            sel_sync_q <= 2'b00;
            state_q    <= ST_RUN;
            resume_q   <= ST_RUN;
            tick_cnt_q <= {TW{1'b0}};
            adj_cnt_q  <= {AW{1'b0}};
            cnt_en_q   <= 1'b0;
            adj_tick_q <= 1'b0;
            adj_min_q  <= 1'b0;
            adj_sec_q  <= 1'b0;
            clr_q      <= 1'b0;
            paused_q   <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            adj_sync_q <= adj_sync_d;
            sel_sync_q <= sel_sync_d;
            state_q    <= state_d;
            resume_q   <= resume_d;
            tick_cnt_q <= tick_cnt_d;
            adj_cnt_q  <= adj_cnt_d;
            cnt_en_q   <= cnt_en_d;
            adj_tick_q <= adj_tick_d;
            adj_min_q  <= adj_min_d;
            adj_sec_q  <= adj_sec_d;
            clr_q      <= clr_d;
            paused_q   <= paused_d;
            blink_q    <= blink_d;
        end
    end

    assign cnt_en   = cnt_en_q;
    assign adj_tick = adj_tick_q;
    assign adj_min  = adj_min_q;
    assign adj_sec  = adj_sec_q;
    assign clr      = clr_q;
    assign paused   = paused_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with CLK_HZ=20, TICK_HZ=1, ADJ_HZ=2, DB_CYCLES=4.
// A clean press driven during cycle c yields the press pulse at c+6 and its effect at c+7.
module tb_stopwatch_ctrl;

    localparam int K_CNT = 0;
    localparam int K_ADJ = 1;
    localparam int K_CLR = 2;

    typedef struct {
        int   kind;
        int   cyc;
        logic blink;
        logic amin;
        logic asec;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_pause = 1'b0;
    logic btn_reset = 1'b0;
    logic sw_adj = 1'b0;
    logic sw_sel = 1'b0;
    logic cnt_en, adj_tick, adj_min, adj_sec, clr, paused, blink;

    int  cyc;
    int  n_checks = 0;
    int  n_pass = 0;
    ev_t exp_q[$];

    stopwatch_ctrl #(
        .CLK_HZ    (20),
        .TICK_HZ   (1),
        .ADJ_HZ    (2),
        .DB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_pause (btn_pause),
        .btn_reset (btn_reset),
        .sw_adj    (sw_adj),
        .sw_sel    (sw_sel),
        .cnt_en    (cnt_en),
        .adj_tick  (adj_tick),
        .adj_min   (adj_min),
        .adj_sec   (adj_sec),
        .clr       (clr),
        .paused    (paused),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset release: after active edge n, cyc == n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    endtask

    task automatic push(input int k, input int c, input logic b, input logic mn, input logic sc);
        ev_t e;
        e.kind = k; e.cyc = c; e.blink = b; e.amin = mn; e.asec = sc;
        exp_q.push_back(e);
    endtask

    task automatic match(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event at cycle %0d: got kind %0d, expected no event", cyc, k);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (k == K_ADJ) begin
                chk("adj_blink", int'(blink), int'(e.blink));
                chk("adj_min", int'(adj_min), int'(e.amin));
                chk("adj_sec", int'(adj_sec), int'(e.asec));
            end
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cnt_en)   match(K_CNT);
            if (adj_tick) match(K_ADJ);
            if (clr)      match(K_CLR);
        end
    end

    task automatic goto(input int c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) begin
            n_checks++;
            $display("FAIL goto_timeout: reached cycle %0d, wanted %0d", cyc, c);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt_en"},   int'(cnt_en),   0);
        chk({tag, "_adj_tick"}, int'(adj_tick), 0);
        chk({tag, "_clr"},      int'(clr),      0);
        chk({tag, "_paused"},   int'(paused),   0);
        chk({tag, "_blink"},    int'(blink),    0);
        chk({tag, "_adj_min"},  int'(adj_min),  0);
        chk({tag, "_adj_sec"},  int'(adj_sec),  0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        push(K_CNT, 20, 1'b0, 1'b0, 1'b0);
        push(K_CNT, 40, 1'b0, 1'b0, 1'b0);
        push(K_CNT, 60, 1'b0, 1'b0, 1'b0);
        goto(5);
        chk_all_zero("after_release");

        // Pause press lands at edge 65 with the tick divider at 5.
        goto(58); btn_pause = 1'b1;
        goto(66); chk("paused_after_press", int'(paused), 1);
        goto(68); btn_pause = 1'b0;
        goto(90); btn_pause = 1'b1;
        push(K_CNT, 112, 1'b0, 1'b0, 1'b0);
        push(K_CNT, 132, 1'b0, 1'b0, 1'b0);
        goto(95); chk("paused_before_resume", int'(paused), 1);
        goto(100); btn_pause = 1'b0;
        chk("running_after_resume", int'(paused), 0);

        // Chatter: 2-cycle toggles never reach 4 stable samples; stable high from 127.
        for (int i = 0; i < 6; i++) begin
            goto(115 + 2 * i);
            btn_pause = (i % 2 == 0) ? 1'b1 : 1'b0;
        end
        goto(127); btn_pause = 1'b1;
        goto(137); btn_pause = 1'b0;
        goto(150); chk("chatter_single_press", int'(paused), 1);

        // Reset press while paused: one clr, stays paused, divider back to 0.
        btn_reset = 1'b1;
        push(K_CLR, 157, 1'b0, 1'b0, 1'b0);
        goto(160); btn_reset = 1'b0;
        goto(165); chk("paused_after_clr", int'(paused), 1);
        goto(170); btn_pause = 1'b1;
        push(K_CNT, 197, 1'b0, 1'b0, 1'b0);
        goto(180); btn_pause = 1'b0;
        chk("running_after_clr_resume", int'(paused), 0);

        // ADJUST on minutes: entry at edge 203, ticks every 10 cycles.
        goto(200); sw_sel = 1'b1; sw_adj = 1'b1;
        push(K_ADJ, 213, 1'b1, 1'b1, 1'b0);
        push(K_ADJ, 223, 1'b0, 1'b1, 1'b0);
        push(K_ADJ, 233, 1'b1, 1'b1, 1'b0);
        goto(205);
        chk("adj_min_level", int'(adj_min), 1);
        chk("adj_sec_level", int'(adj_sec), 0);
        chk("adj_paused", int'(paused), 0);
        chk("adj_blink_start", int'(blink), 0);
        goto(215); chk("blink_after_tick", int'(blink), 1);
        goto(235); sw_adj = 1'b0;
        push(K_CNT, 252, 1'b0, 1'b0, 1'b0);
        push(K_CNT, 272, 1'b0, 1'b0, 1'b0);
        goto(240);
        chk("exit_adj_min", int'(adj_min), 0);
        chk("exit_blink", int'(blink), 0);
        goto(260); sw_sel = 1'b0;

        // ADJUST on seconds, then a one-cycle rst_n pulse mid-ADJUST.
        goto(275); sw_adj = 1'b1;
        push(K_ADJ, 288, 1'b1, 1'b0, 1'b1);
        goto(280);
        chk("adj_sec_level2", int'(adj_sec), 1);
        chk("adj_min_level2", int'(adj_min), 0);
        goto(292);
        rst_n = 1'b0;
        sw_adj = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("reset_release");
        push(K_CNT, 20, 1'b0, 1'b0, 1'b0);
        push(K_CNT, 40, 1'b0, 1'b0, 1'b0);
        goto(10);
        chk("post_reset_paused", int'(paused), 0);
        chk("post_reset_adj_sec", int'(adj_sec), 0);
        goto(45);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
